// File: rtl/trans_pkg.sv
// Shared types and exception codes for the IF/MEM address-translation scheduler.
package trans_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_XLATE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  // Returns {excp, ecode}; checks are ordered so the highest-priority fault wins.
  function automatic logic [6:0] tlb_check(
    input logic       is_mem,
    input logic       is_store,
    input logic [1:0] cur_plv,
    input logic       hit,
    input logic       v,
    input logic       d,
    input logic [1:0] page_plv
  );
    logic [6:0] r;
    r = 7'b0;
    if (!hit)
      r = {1'b1, ECODE_TLBR};
    else if (!v)
      r = {1'b1, !is_mem ? ECODE_PIF : (is_store ? ECODE_PIS : ECODE_PIL)};
    else if (cur_plv > page_plv)
      r = {1'b1, ECODE_PPI};
    else if (is_store && !d)
      r = {1'b1, ECODE_PME};
    return r;
  endfunction

endpackage

// File: rtl/trans_rr_arb.sv
// Two-way round-robin arbiter: bit 0 is IF, bit 1 is MEM.
module trans_rr_arb
  import trans_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // On contention the requester that was not served last time wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11)
      gnt = (last_grant == REQ_MEM) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/trans_req_sched.sv
// Schedules the shared addr_trans/TLB search path between IF and MEM, one request in flight.
module trans_req_sched
  import trans_pkg::*;
#(
  parameter int TLB_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic [1:0]  csr_plv,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_vaddr,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic [31:0] mem_vaddr,
  input  logic        mem_is_store,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_paddr,
  output logic [1:0]  resp_mat,
  output logic        resp_excp,
  output logic [5:0]  resp_ecode,
  output logic [31:0] at_vaddr,
  input  logic [31:0] at_paddr,
  input  logic        at_is_usetlb,
  input  logic [1:0]  at_mat,
  output logic        tlb_s_valid,
  output logic [18:0] tlb_s_vppn,
  output logic        tlb_s_odd,
  input  logic        tlb_s_hit,
  input  logic        tlb_s_v,
  input  logic        tlb_s_d,
  input  logic [1:0]  tlb_s_plv
);

  state_t      state, state_nxt;
  logic        last_grant;
  logic [31:0] vaddr_q;
  logic        id_q;
  logic        store_q;
  logic [7:0]  cnt;
  logic [31:0] paddr_q;
  logic [1:0]  mat_q;
  logic        excp_q;
  logic [5:0]  ecode_q;
  logic [1:0]  gnt;
  logic        accept;
  logic        tlb_done;
  logic [6:0]  chk;

  trans_rr_arb u_arb (
    .req        ({mem_req_valid, if_req_valid}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign if_req_ready  = (state == S_IDLE) && !flush && gnt[0];
  assign mem_req_ready = (state == S_IDLE) && !flush && gnt[1];
  assign accept        = (if_req_ready && if_req_valid) || (mem_req_ready && mem_req_valid);
  assign tlb_done      = (state == S_WAIT) && (cnt == 8'(TLB_LAT - 1));
  assign chk           = tlb_check(id_q, store_q, csr_plv, tlb_s_hit, tlb_s_v, tlb_s_d, tlb_s_plv);

  // The latched vaddr stays on addr_trans for the whole request so at_paddr is valid when sampled.
  assign at_vaddr    = vaddr_q;
  assign tlb_s_valid = (state == S_XLATE) && at_is_usetlb;
  assign tlb_s_vppn  = vaddr_q[31:13];
  assign tlb_s_odd   = vaddr_q[12];

  assign resp_valid = (state == S_RESP);
  assign resp_id    = id_q;
  assign resp_paddr = paddr_q;
  assign resp_mat   = mat_q;
  assign resp_excp  = excp_q;
  assign resp_ecode = ecode_q;

  always_ff @(posedge clk) begin
    if (!rstn)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Flush beats a same-cycle response handshake, so the response counts as undelivered.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_XLATE;
      S_XLATE: state_nxt = flush ? S_IDLE : (at_is_usetlb ? S_WAIT : S_RESP);
      S_WAIT:  if (flush) state_nxt = S_IDLE;
               else if (tlb_done) state_nxt = S_RESP;
      S_RESP:  if (flush || resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_grant <= REQ_MEM;
      vaddr_q    <= '0;
      id_q       <= 1'b0;
      store_q    <= 1'b0;
      cnt        <= '0;
      paddr_q    <= '0;
      mat_q      <= '0;
      excp_q     <= 1'b0;
      ecode_q    <= '0;
    end else begin
      if (accept) begin
        id_q    <= mem_req_ready;
        vaddr_q <= mem_req_ready ? mem_vaddr : if_vaddr;
        store_q <= mem_req_ready && mem_is_store;
      end
      if (state == S_XLATE)
        cnt <= '0;
      else if (state == S_WAIT)
        cnt <= cnt + 8'd1;
      if (state == S_XLATE && !at_is_usetlb) begin
        paddr_q <= at_paddr;
        mat_q   <= at_mat;
        excp_q  <= 1'b0;
        ecode_q <= '0;
      end
      if (tlb_done) begin
        paddr_q <= chk[6] ? 32'h0 : at_paddr;
        mat_q   <= at_mat;
        excp_q  <= chk[6];
        ecode_q <= chk[5:0];
      end
      if (state == S_RESP && resp_ready && !flush)
        last_grant <= id_q;
    end
  end

endmodule
